// File: rtl/simple_dual_port_ram_fifo_controller_if.sv
// Bundle of producer, consumer and RAM-port signals around the FIFO controller.
// master = producer/consumer/RAM side, slave = the controller itself.
interface simple_dual_port_ram_fifo_controller_if #(
    parameter int WIDTH         = 8,
    parameter int ADDRESS_WIDTH = 4
);
    logic                     flush;
    logic                     write_enable;
    logic [WIDTH-1:0]         write_data;
    logic                     full;
    logic                     almost_full;
    logic                     read_enable;
    logic [WIDTH-1:0]         read_data;
    logic                     read_valid;
    logic                     empty;
    logic                     almost_empty;
    logic [ADDRESS_WIDTH:0]   level;
    logic                     overflow;
    logic                     underflow;
    logic                     memory_write_enable;
    logic [ADDRESS_WIDTH-1:0] memory_write_address;
    logic [WIDTH-1:0]         memory_write_data;
    logic                     memory_read_enable;
    logic [ADDRESS_WIDTH-1:0] memory_read_address;
    logic [WIDTH-1:0]         memory_read_data;

    modport master (
        output flush, write_enable, write_data, read_enable, memory_read_data,
        input  full, almost_full, read_data, read_valid, empty, almost_empty,
               level, overflow, underflow, memory_write_enable,
               memory_write_address, memory_write_data, memory_read_enable,
               memory_read_address
    );

    modport slave (
        input  flush, write_enable, write_data, read_enable, memory_read_data,
        output full, almost_full, read_data, read_valid, empty, almost_empty,
               level, overflow, underflow, memory_write_enable,
               memory_write_address, memory_write_data, memory_read_enable,
               memory_read_address
    );
endinterface

// File: rtl/simple_dual_port_ram_fifo_controller.sv
// FIFO controller sequencing an external simple dual-port RAM with registered read.
// Owns wrap-bit pointers, status flags, sticky error bits and synchronous flush.
module simple_dual_port_ram_fifo_controller #(
    parameter int WIDTH                  = 8,
    parameter int DEPTH                  = 16,
    parameter int ADDRESS_WIDTH          = $clog2(DEPTH),
    parameter int ALMOST_FULL_THRESHOLD  = DEPTH - 2,
    parameter int ALMOST_EMPTY_THRESHOLD = 2
) (
    input  logic i_clock,
    input  logic i_resetn,
    simple_dual_port_ram_fifo_controller_if.slave bus
);
    localparam int LP_PTR_WIDTH = ADDRESS_WIDTH + 1;
    localparam logic [ADDRESS_WIDTH:0] LP_PTR_ONE      = LP_PTR_WIDTH'(1);
    localparam logic [ADDRESS_WIDTH:0] LP_ALMOST_FULL  = LP_PTR_WIDTH'(ALMOST_FULL_THRESHOLD);
    localparam logic [ADDRESS_WIDTH:0] LP_ALMOST_EMPTY = LP_PTR_WIDTH'(ALMOST_EMPTY_THRESHOLD);

    logic [ADDRESS_WIDTH:0] r_write_pointer;
    logic [ADDRESS_WIDTH:0] r_read_pointer;
    logic                   r_read_valid;
    logic                   r_overflow;
    logic                   r_underflow;

    logic [ADDRESS_WIDTH:0] w_level;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_write_accept;
    logic                   w_read_accept;

    // Status depends only on the registered pointers.
    assign w_level = r_write_pointer - r_read_pointer;
    assign w_empty = (r_write_pointer == r_read_pointer);
    assign w_full  = (r_write_pointer[ADDRESS_WIDTH-1:0] == r_read_pointer[ADDRESS_WIDTH-1:0])
                  && (r_write_pointer[ADDRESS_WIDTH] != r_read_pointer[ADDRESS_WIDTH]);

    // Gating with i_resetn keeps the RAM strobes low while reset is held.
    assign w_write_accept = bus.write_enable & ~w_full  & ~bus.flush & i_resetn;
    assign w_read_accept  = bus.read_enable  & ~w_empty & ~bus.flush & i_resetn;

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_write_pointer <= '0;
            r_read_pointer  <= '0;
            r_read_valid    <= 1'b0;
            r_overflow      <= 1'b0;
            r_underflow     <= 1'b0;
        end else if (bus.flush) begin
            r_write_pointer <= '0;
            r_read_pointer  <= '0;
            r_read_valid    <= 1'b0;
            r_overflow      <= 1'b0;
            r_underflow     <= 1'b0;
        end else begin
            if (w_write_accept) begin
                r_write_pointer <= r_write_pointer + LP_PTR_ONE;
            end
            if (w_read_accept) begin
                r_read_pointer <= r_read_pointer + LP_PTR_ONE;
            end
            r_read_valid <= w_read_accept;
            r_overflow   <= r_overflow  | (bus.write_enable & w_full);
            r_underflow  <= r_underflow | (bus.read_enable  & w_empty);
        end
    end

    assign bus.level        = w_level;
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (w_level >= LP_ALMOST_FULL);
    assign bus.almost_empty = (w_level <= LP_ALMOST_EMPTY);
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;
    assign bus.read_valid   = r_read_valid;
    assign bus.read_data    = bus.memory_read_data;

    assign bus.memory_write_enable  = w_write_accept;
    assign bus.memory_write_address = r_write_pointer[ADDRESS_WIDTH-1:0];
    assign bus.memory_write_data    = bus.write_data;
    assign bus.memory_read_enable   = w_read_accept;
    assign bus.memory_read_address  = r_read_pointer[ADDRESS_WIDTH-1:0];
endmodule

// File: doc/simple_dual_port_ram_fifo_controller.md
# simple_dual_port_ram_fifo_controller

Single-clock FIFO controller that sequences an external synchronous simple dual-port RAM (one write port, one read port, registered read data with one-cycle latency). It owns the write/read pointers, occupancy and status flags, and generates the RAM write and read strobes and addresses. It sits between producer/consumer logic and a simple dual-port RAM instance, which turns that RAM into a FIFO with sticky error reporting and synchronous flush.

## Interface

- WIDTH, 8, data word width in bits
- DEPTH, 16, number of RAM entries; power of two, at least 2
- ADDRESS_WIDTH, `CLOG2(DEPTH)`, RAM address width
- ALMOST_FULL_THRESHOLD, DEPTH-2, almost_full asserted when level ≥ this value
- ALMOST_EMPTY_THRESHOLD, 2, almost_empty asserted when level ≤ this value

- clock  in  1  single clock; all state updates on its rising edge
- resetn  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of FIFO state
- write_enable  in  1  producer push request
- write_data  in  WIDTH  word to push
- full  out  1  FIFO holds DEPTH words
- almost_full  out  1  level ≥ ALMOST_FULL_THRESHOLD
- read_enable  in  1  consumer pop request
- read_data  out  WIDTH  popped word; valid when read_valid is high
- read_valid  out  1  read_data carries the word popped in the previous cycle
- empty  out  1  FIFO holds no words
- almost_empty  out  1  level ≤ ALMOST_EMPTY_THRESHOLD
- level  out  ADDRESS_WIDTH+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty
- memory_write_enable  out  1  RAM write strobe
- memory_write_address  out  ADDRESS_WIDTH  RAM write address
- memory_write_data  out  WIDTH  RAM write data
- memory_read_enable  out  1  RAM read strobe
- memory_read_address  out  ADDRESS_WIDTH  RAM read address
- memory_read_data  in  WIDTH  RAM registered read data, one cycle after memory_read_enable

## Operation

- Pointers: write_pointer and read_pointer, each ADDRESS_WIDTH+1 bits, increment modulo 2^(ADDRESS_WIDTH+1); the low ADDRESS_WIDTH bits address the RAM, and the MSB is the wrap bit.
- empty = pointers equal; full = low bits equal and MSBs differ; level = write_pointer − read_pointer (modulo 2^(ADDRESS_WIDTH+1)).
- full, empty, level, almost_full and almost_empty are derived from registered pointers only, with no combinational path from any input.
- Write accepted = write_enable & !full & !flush. The block then drives memory_write_enable=1, memory_write_address=write_pointer low bits and memory_write_data=write_data combinationally, and increments write_pointer.
- Read accepted = read_enable & !empty & !flush. The block then drives memory_read_enable=1 and memory_read_address=read_pointer low bits combinationally, and increments read_pointer.
- Memory strobes are 0 whenever the corresponding request is not accepted. Addresses and write data may hold any value while the strobe is low.
- read_valid is a register loaded each cycle with read accepted. read_data = memory_read_data as a combinational passthrough.
- Simultaneous write and read:
  - Both accepted: level unchanged.
  - When full: the read is accepted, the write is rejected, and overflow is set (full is the current-cycle state).
  - When empty: the write is accepted, the read is rejected, and underflow is set; there is no bypass.
- overflow is set by write_enable & full & !flush. underflow is set by read_enable & empty & !flush. Both stay set until flush or reset.
- flush has priority over everything. Next cycle: both pointers are 0, overflow=0, underflow=0, read_valid=0. No memory strobe is asserted in the flush cycle. RAM contents are untouched.
- Reset values: pointers 0, level 0, empty 1, almost_empty 1, full 0, almost_full 0, read_valid 0, overflow 0, underflow 0. Memory strobes are 0 throughout reset.
- Reset asserted mid-operation clears all state immediately, and any in-flight read_valid is dropped.

## Timing

- Accepted write in cycle N: level, empty and full update in cycle N+1. A read of that word can be accepted at N+1 at the earliest.
- Accepted read in cycle N: RAM address presented in N, read_valid=1 and read_data valid in N+1.
- Sustained throughput is one write and one read per cycle with no bubbles.
- Write-to-read data latency is 2 cycles when starting from empty.
- A RAM read never targets the address written in the same cycle unless the FIFO is full with both requests accepted on the same slot. That case cannot occur, because the write is rejected when full.

## Test plan

- Reset, then 16 writes of 0x00..0x0F with DEPTH=16 → full=1 and level=16 after the 16th; almost_full rises when level reaches 14; a 17th write leaves level at 16 and sets overflow.
- Drain 16 reads from full → read_data sequence 0x00..0x0F, each one cycle after its read; empty=1 after the last; a 17th read sets underflow and read_valid stays 0.
- Continuous simultaneous write/read for 40 cycles starting at level 3 → level stays 3, output order is preserved across pointer wrap, and the wrap bit toggles after each 16 operations.
- Write 0xA5 when empty with read_enable high in the same cycle → read rejected and underflow=1; a read the next cycle returns 0xA5 one cycle later.
- flush at level 9 with write_enable and read_enable high → no memory strobes that cycle; next cycle level=0, empty=1, overflow and underflow cleared, read_valid=0.
- resetn pulsed low mid-drain at level 5 with a read accepted the previous cycle → all outputs return to reset values asynchronously, and read_valid drops immediately.
